// File: rtl/mcpu_mem_arbiter_pkg.sv
// Shared definitions for the MCPU memory-port arbiter: FSM state encoding,
// requester index assignments and the default word-address width.
package mcpu_mem_arbiter_pkg;

  // Word-address width of the MCPU memory port (32-bit words, 4 GiB byte space).
  localparam int MEM_AW = 30;

  // Fixed requester slots on the shared port.
  localparam int REQ_IFETCH = 0;
  localparam int REQ_DATA   = 1;
  localparam int REQ_DEBUG  = 2;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Increment an index and wrap it at n (not at a power of two).
  function automatic int wrap_inc(input int idx, input int n);
    int nxt;
    nxt = idx + 1;
    if (nxt >= n) begin
      nxt = 0;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mcpu_mem_arbiter_if.sv
// Bundle of the requester-side and memory-side handshake signals of the
// arbiter. The slave modport is the arbiter's view; the master modport is the
// view of the environment (requesters plus memory model/controller).
interface mcpu_mem_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 30
);

  // Requester side (packed, requester i at slice i)
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*4-1:0]    req_wen;
  logic [NREQ*32-1:0]   req_wdata;
  logic [NREQ-1:0]      resp_valid;
  logic [31:0]          resp_rdata;

  // Memory side
  logic                 mem_valid;
  logic                 mem_ready;
  logic [AW-1:0]        mem_addr;
  logic [3:0]           mem_wen;
  logic [31:0]          mem_wdata;
  logic                 mem_rvalid;
  logic [31:0]          mem_rdata;

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata,
    output req_ready, resp_valid, resp_rdata,
    output mem_valid, mem_addr, mem_wen, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output req_valid, req_addr, req_wen, req_wdata,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_valid, mem_addr, mem_wen, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mcpu_mem_arbiter_rr_pick.sv
// Combinational round-robin priority picker: returns the first asserted
// request found when scanning upward from rr_ptr, wrapping modulo NREQ.
// rr_ptr must be below NREQ; results never name an index >= NREQ.
module mcpu_rr_pick #(
  parameter int NREQ = 3,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] rr_ptr,
  output logic            any,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] idx
);

  int              cand_s;
  logic [NREQ-1:0] req_shift_s;

  // Scan NREQ candidates starting at rr_ptr; the first hit wins.
  always_comb begin
    any         = 1'b0;
    grant       = {NREQ{1'b0}};
    idx         = {IDXW{1'b0}};
    cand_s      = 0;
    req_shift_s = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      cand_s = int'(rr_ptr) + i;
      if (cand_s >= NREQ) begin
        cand_s = cand_s - NREQ;
      end else begin
        cand_s = cand_s;
      end
      req_shift_s = req >> cand_s;
      if (!any && req_shift_s[0]) begin
        any   = 1'b1;
        grant = {{(NREQ-1){1'b0}}, 1'b1} << cand_s;
        idx   = IDXW'(cand_s);
      end else begin
        any   = any;
      end
    end
  end

endmodule

// File: rtl/mcpu_mem_arbiter.sv
// Arbiter sharing the MCPU core's single 32-bit memory port between NREQ
// requesters (0 = instruction fetch, 1 = data load/store, 2 = debug).
// Round-robin grant, one outstanding transaction, registered response strobe.
// IDXW must satisfy 2**IDXW >= NREQ.
module mcpu_mem_arbiter
  import mcpu_mem_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = MEM_AW,
  parameter int IDXW = 2
) (
  input  logic              clkrst_core_clk,
  input  logic              clkrst_core_rst,
  mcpu_mem_arbiter_if.slave bus,
  output logic              busy,
  output logic [IDXW-1:0]   owner
);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [3:0]      wen_q, wen_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [31:0]     resp_rdata_q, resp_rdata_d;

  logic            pick_any_s;
  logic [NREQ-1:0] pick_grant_s;
  logic [IDXW-1:0] pick_idx_s;
  logic [NREQ-1:0] req_ready_s;
  logic            mem_valid_s;

  mcpu_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any_s),
    .grant  (pick_grant_s),
    .idx    (pick_idx_s)
  );

  // Next-state, datapath capture and handshake outputs of the arbiter FSM.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    resp_valid_d = {NREQ{1'b0}};
    resp_rdata_d = resp_rdata_q;
    req_ready_s  = {NREQ{1'b0}};
    mem_valid_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          // Grant is visible to the winner in the same cycle it is decided.
          req_ready_s = pick_grant_s;
          addr_d      = AW'(bus.req_addr >> (int'(pick_idx_s) * AW));
          wen_d       = 4'(bus.req_wen >> (int'(pick_idx_s) * 4));
          wdata_d     = 32'(bus.req_wdata >> (int'(pick_idx_s) * 32));
          owner_d     = pick_idx_s;
          rr_ptr_d    = IDXW'(wrap_inc(int'(pick_idx_s), NREQ));
          state_d     = ST_ISSUE;
        end else begin
          state_d     = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        // Completion strobes are not expected before acceptance and are ignored here.
        mem_valid_s = 1'b1;
        if (bus.mem_ready) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end

      ST_WAIT: begin
        if (bus.mem_rvalid) begin
          resp_valid_d = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
          resp_rdata_d = bus.mem_rdata;
          state_d      = ST_IDLE;
        end else begin
          state_d      = ST_WAIT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= {IDXW{1'b0}};
      owner_q      <= {IDXW{1'b0}};
      addr_q       <= {AW{1'b0}};
      wen_q        <= 4'd0;
      wdata_q      <= 32'd0;
      resp_valid_q <= {NREQ{1'b0}};
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_valid  = mem_valid_s;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wen    = wen_q;
  assign bus.mem_wdata  = wdata_q;
  assign busy           = (state_q != ST_IDLE);
  assign owner          = owner_q;

endmodule

// File: tb/tb_mcpu_mem_arbiter.sv
// Self-checking bench for mcpu_mem_arbiter: directed scenarios followed by a
// randomized phase, all checked against a small behavioural model of the
// grant order and a word-addressed memory image.
module tb_mcpu_mem_arbiter;
  import mcpu_mem_arbiter_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 30;
  localparam int IDXW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            busy;
  logic [IDXW-1:0] owner;

  always #5 clk = ~clk;

  mcpu_mem_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus ();

  mcpu_mem_arbiter #(.NREQ(NREQ), .AW(AW), .IDXW(IDXW)) dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .bus             (bus),
    .busy            (busy),
    .owner           (owner)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: round-robin pointer, per-requester payloads, memory image.
  int            m_ptr = 0;
  logic [AW-1:0] r_addr  [NREQ];
  logic [3:0]    r_wen   [NREQ];
  logic [31:0]   r_wdata [NREQ];
  logic [31:0]   mem_words [logic [AW-1:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first valid requester at or after the pointer, modulo NREQ.
  function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] mem_read(input logic [AW-1:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return 32'(a) ^ 32'h5A5A_0000;
  endfunction

  task automatic drive_payload();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i*AW +: AW]  = r_addr[i];
      bus.req_wen[i*4 +: 4]     = r_wen[i];
      bus.req_wdata[i*32 +: 32] = r_wdata[i];
    end
  endtask

  task automatic raise(input int i, input logic [AW-1:0] a, input logic [3:0] we, input logic [31:0] wd);
    r_addr[i]        = a;
    r_wen[i]         = we;
    r_wdata[i]       = wd;
    bus.req_valid[i] = 1'b1;
    drive_payload();
  endtask

  task automatic raise_random(input int i);
    logic [3:0] we;
    we = ($urandom_range(1, 0) == 1) ? 4'($urandom) : 4'd0;
    raise(i, AW'($urandom_range(15, 0)), we, $urandom);
  endtask

  // One full transaction from the current (IDLE) cycle; ends #1 after the edge
  // that raises resp_valid, so the caller may present a new request in that cycle.
  task automatic run_txn(input int ready_dly, input int rvalid_dly,
                         input logic [31:0] rd_override, input bit use_override,
                         output int granted);
    int          w;
    logic [31:0] exp_rd;
    logic [31:0] merged;
    w = model_pick(bus.req_valid, m_ptr);
    granted = w;
    @(negedge clk);
    chk("grant", 64'(bus.req_ready), 64'(1) << w);
    chk("busy_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
    bus.req_valid[w] = 1'b0;
    m_ptr = (w + 1) % NREQ;
    for (int c = 0; c <= ready_dly; c++) begin
      bus.mem_ready = (c == ready_dly);
      @(negedge clk);
      chk("mem_valid_issue", 64'(bus.mem_valid), 64'd1);
      chk("mem_addr", 64'(bus.mem_addr), 64'(r_addr[w]));
      chk("mem_wen", 64'(bus.mem_wen), 64'(r_wen[w]));
      chk("mem_wdata", 64'(bus.mem_wdata), 64'(r_wdata[w]));
      chk("no_ready_busy", 64'(bus.req_ready), 64'd0);
      chk("busy_issue", 64'(busy), 64'd1);
      chk("owner_issue", 64'(owner), 64'(w));
      if (c == 0) chk("resp_one_cycle", 64'(bus.resp_valid), 64'd0);
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
    if (r_wen[w] == 4'd0) begin
      exp_rd = use_override ? rd_override : mem_read(r_addr[w]);
    end else begin
      merged = mem_read(r_addr[w]);
      for (int b = 0; b < 4; b++) begin
        if (r_wen[w][b]) merged[b*8 +: 8] = r_wdata[w][b*8 +: 8];
      end
      mem_words[r_addr[w]] = merged;
      exp_rd = $urandom;
    end
    for (int c = 0; c <= rvalid_dly; c++) begin
      bus.mem_rvalid = (c == rvalid_dly);
      bus.mem_rdata  = (c == rvalid_dly) ? exp_rd : $urandom;
      @(negedge clk);
      chk("mem_valid_wait", 64'(bus.mem_valid), 64'd0);
      chk("no_resp_wait", 64'(bus.resp_valid), 64'd0);
      chk("busy_wait", 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    bus.mem_rvalid = 1'b0;
    chk("resp_valid", 64'(bus.resp_valid), 64'(1) << w);
    chk("resp_rdata", 64'(bus.resp_rdata), 64'(exp_rd));
    chk("busy_done", 64'(busy), 64'd0);
    chk("owner_done", 64'(owner), 64'(w));
  endtask

  initial begin
    int g;
    bus.req_valid  = '0;
    bus.req_addr   = '0;
    bus.req_wen    = '0;
    bus.req_wdata  = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;
    for (int i = 0; i < NREQ; i++) begin
      r_addr[i] = '0; r_wen[i] = 4'd0; r_wdata[i] = 32'd0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
    @(posedge clk); #1;

    // Single read with minimum latency
    raise(REQ_IFETCH, 30'h10, 4'd0, 32'd0);
    run_txn(0, 0, 32'hDEAD_BEEF, 1'b1, g);

    // Write from the data port
    raise(REQ_DATA, 30'h20, 4'b0011, 32'h1234_5678);
    run_txn(0, 0, 32'd0, 1'b0, g);

    // Round-robin with all requesters continuously valid, from a fresh pointer
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_ptr = 0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i]) raise_random(i);
      end
      run_txn(0, 0, 32'd0, 1'b0, g);
      chk("rr_order", 64'(g), 64'(k % NREQ));
    end
    bus.req_valid = '0;

    // Backpressure: mem_ready low for 5 cycles
    raise(REQ_IFETCH, 30'h3, 4'd0, 32'd0);
    run_txn(5, 1, 32'd0, 1'b0, g);

    // Reset while in WAIT, then a stray completion strobe
    raise(REQ_DEBUG, 30'h7, 4'd0, 32'd0);
    @(negedge clk);
    chk("rst_wait_grant", 64'(bus.req_ready), 64'b100);
    @(posedge clk); #1;
    bus.req_valid[REQ_DEBUG] = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_ptr = 0;
    chk("midwait_busy", 64'(busy), 64'd0);
    chk("midwait_resp", 64'(bus.resp_valid), 64'd0);
    chk("midwait_owner", 64'(owner), 64'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    chk("stray_mem_valid", 64'(bus.mem_valid), 64'd0);
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    chk("stray_rvalid_resp", 64'(bus.resp_valid), 64'd0);
    chk("stray_rvalid_busy", 64'(busy), 64'd0);
    for (int i = 0; i < NREQ; i++) raise_random(i);
    run_txn(0, 0, 32'd0, 1'b0, g);
    chk("after_rst_first", 64'(g), 64'd0);
    run_txn(1, 0, 32'd0, 1'b0, g);
    run_txn(0, 2, 32'd0, 1'b0, g);

    // Back-to-back: requester 2 re-requests in its own resp_valid cycle
    raise_random(REQ_DEBUG);
    run_txn(0, 0, 32'd0, 1'b0, g);
    raise_random(REQ_DEBUG);
    run_txn(0, 0, 32'd0, 1'b0, g);
    chk("b2b_owner", 64'(g), 64'd2);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && ($urandom_range(1, 0) == 1)) raise_random(i);
      end
      if (bus.req_valid == '0) raise_random($urandom_range(NREQ - 1, 0));
      run_txn($urandom_range(3, 0), $urandom_range(3, 0), 32'd0, 1'b0, g);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
